// File: rtl/posit_extract_pipe.sv
// posit_extract_pipe
//   Two-stage pipelined posit decoder. Turns a raw NBITS/ES posit word into
//   the unpacked form the posit arithmetic units use: sign, signed scale,
//   exponent field, MSB-aligned fraction (hidden bit excluded) and
//   zero / NaR flags. A user tag travels alongside each word.
//
//   Ports:
//     clk, reset             rising-edge clock, asynchronous active-high reset
//     in_valid/in_ready      input handshake; in_ready = !out_valid | out_ready
//     in_data [NBITS]        raw posit word
//     in_tag  [TBITS]        sideband, passed through unchanged
//     out_valid/out_ready    output handshake
//     out_sign               sign
//     out_scale [SBITS]      signed scale k*2^ES + exponent
//     out_exponent [ES]      exponent field (1 bit wide, tied to 0 when ES=0)
//     out_fraction [FBITS]   fraction, MSB-aligned, zero-filled
//     out_inf, out_zero      NaR / zero flags (all other fields 0 when set)
//     out_tag [TBITS]        tag paired with this result
module posit_extract_pipe #(
  parameter int NBITS = 32,
  parameter int ES    = 2,
  parameter int TBITS = 8,
  localparam int FBITS = NBITS - 3 - ES,
  localparam int SBITS = $clog2(NBITS) + ES + 1,
  localparam int EW    = (ES > 0) ? ES : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [NBITS-1:0] in_data,
  input  logic [TBITS-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sign,
  output logic [SBITS-1:0] out_scale,
  output logic [EW-1:0]    out_exponent,
  output logic [FBITS-1:0] out_fraction,
  output logic             out_inf,
  output logic             out_zero,
  output logic [TBITS-1:0] out_tag
);

  // Regime run length is 1..NBITS-1, so clog2(NBITS) bits are enough.
  localparam int MW = $clog2(NBITS);

  localparam logic [NBITS-1:0] INF_PAT = {1'b1, {(NBITS-1){1'b0}}};
  localparam logic [NBITS-1:0] ZERO_N  = {NBITS{1'b0}};
  localparam logic [NBITS-2:0] ONE_B   = {{(NBITS-2){1'b0}}, 1'b1};
  localparam logic [MW-1:0]    ONE_M   = {{(MW-1){1'b0}}, 1'b1};
  localparam logic signed [SBITS-1:0] ONE_S  = {{(SBITS-1){1'b0}}, 1'b1};
  localparam logic signed [SBITS-1:0] ZERO_S = {SBITS{1'b0}};

  logic w_en;

  // Stage 1 registers
  logic             r_s1_valid;
  logic             r_s1_sign;
  logic             r_s1_zero;
  logic             r_s1_inf;
  logic [NBITS-2:0] r_s1_body;   // magnitude below the (always clear) top bit
  logic [TBITS-1:0] r_s1_tag;

  // Stage 2 (output) registers
  logic             r_out_valid;
  logic             r_out_sign;
  logic [SBITS-1:0] r_out_scale;
  logic [EW-1:0]    r_out_exponent;
  logic [FBITS-1:0] r_out_fraction;
  logic             r_out_inf;
  logic             r_out_zero;
  logic [TBITS-1:0] r_out_tag;

  // Stage-2 decode wires
  logic [NBITS-2:0]         w_body_in;
  logic                     w_r0;
  logic [MW-1:0]            w_run;
  logic                     w_done;
  logic [NBITS-4:0]         w_tail;
  logic [EW-1:0]            w_exp;
  logic [FBITS-1:0]         w_frac;
  logic signed [SBITS-1:0]  w_run_s;
  logic signed [SBITS-1:0]  w_k;
  logic signed [SBITS-1:0]  w_scale;

  // Global enable: the whole pipe advances unless a valid output is stalled.
  assign w_en     = !r_out_valid || out_ready;
  assign in_ready = w_en;

  // Low bits of the two's complement equal the two's complement of the low
  // bits, so the unused top bit never needs to be formed.
  assign w_body_in = in_data[NBITS-1] ? (~in_data[NBITS-2:0] + ONE_B)
                                      : in_data[NBITS-2:0];

  // Stage 1: capture sign, special flags, magnitude and tag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_sign  <= 1'b0;
      r_s1_zero  <= 1'b0;
      r_s1_inf   <= 1'b0;
      r_s1_body  <= '0;
      r_s1_tag   <= '0;
    end else if (w_en) begin
      r_s1_valid <= in_valid;
      r_s1_sign  <= in_data[NBITS-1];
      r_s1_zero  <= (in_data == ZERO_N);
      r_s1_inf   <= (in_data == INF_PAT);
      r_s1_body  <= w_body_in;
      r_s1_tag   <= in_tag;
    end
  end

  assign w_r0 = r_s1_body[NBITS-2];

  // Regime run length: count bits equal to r0 from the top until the first change.
  always_comb begin
    w_run  = '0;
    w_done = 1'b0;
    for (int i = NBITS - 2; i >= 0; i--) begin
      if (!w_done && (r_s1_body[i] == w_r0)) begin
        w_run = w_run + ONE_M;
      end else begin
        w_done = 1'b1;
      end
    end
  end

  // The regime occupies at least two bits, so exponent+fraction live in the
  // low NBITS-3 bits; shifting them left by run-1 drops the rest of the regime
  // and the terminator. Bits beyond the word end shift in as zeros.
  assign w_tail = r_s1_body[NBITS-4:0] << (w_run - ONE_M);
  assign w_frac = w_tail[FBITS-1:0];

  generate
    if (ES > 0) begin : g_exp
      assign w_exp = w_tail[NBITS-4 -: EW];
    end else begin : g_noexp
      assign w_exp = '0;
    end
  endgenerate

  assign w_run_s = SBITS'(w_run);

  // k = m-1 for a run of ones, -m for a run of zeros.
  always_comb begin
    if (w_r0) begin
      w_k = w_run_s - ONE_S;
    end else begin
      w_k = ZERO_S - w_run_s;
    end
  end

  assign w_scale = (w_k <<< ES) + $signed({{(SBITS-EW){1'b0}}, w_exp});

  // Stage 2: register the decoded fields; specials force everything else to 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_valid    <= 1'b0;
      r_out_sign     <= 1'b0;
      r_out_scale    <= '0;
      r_out_exponent <= '0;
      r_out_fraction <= '0;
      r_out_inf      <= 1'b0;
      r_out_zero     <= 1'b0;
      r_out_tag      <= '0;
    end else if (w_en) begin
      r_out_valid <= r_s1_valid;
      r_out_inf   <= r_s1_inf;
      r_out_zero  <= r_s1_zero;
      r_out_tag   <= r_s1_tag;
      if (r_s1_zero || r_s1_inf) begin
        r_out_sign     <= 1'b0;
        r_out_scale    <= '0;
        r_out_exponent <= '0;
        r_out_fraction <= '0;
      end else begin
        r_out_sign     <= r_s1_sign;
        r_out_scale    <= w_scale;
        r_out_exponent <= w_exp;
        r_out_fraction <= w_frac;
      end
    end
  end

  assign out_valid    = r_out_valid;
  assign out_sign     = r_out_sign;
  assign out_scale    = r_out_scale;
  assign out_exponent = r_out_exponent;
  assign out_fraction = r_out_fraction;
  assign out_inf      = r_out_inf;
  assign out_zero     = r_out_zero;
  assign out_tag      = r_out_tag;

endmodule

// File: tb/tb_posit_extract_pipe.sv
// Self-checking bench for posit_extract_pipe: a 32/2 instance carries the
// main scenarios, a 16/1 instance covers the reparametrised decode.
module tb_posit_extract_pipe;

  typedef struct packed {
    logic        sg;
    logic [7:0]  sc;
    logic [1:0]  ex;
    logic [26:0] fr;
    logic        inf;
    logic        zr;
    logic [7:0]  tg;
  } r32_t;

  typedef struct packed {
    logic        sg;
    logic [5:0]  sc;
    logic        ex;
    logic [11:0] fr;
    logic        inf;
    logic        zr;
    logic [7:0]  tg;
  } r16_t;

  logic clk, reset;

  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_data;
  logic [7:0]  in_tag, out_tag;
  logic        out_sign, out_inf, out_zero;
  logic [7:0]  out_scale;
  logic [1:0]  out_exponent;
  logic [26:0] out_fraction;

  logic        in_valid_h, in_ready_h, out_valid_h, out_ready_h;
  logic [15:0] in_data_h;
  logic [7:0]  in_tag_h, out_tag_h;
  logic        out_sign_h, out_inf_h, out_zero_h;
  logic [5:0]  out_scale_h;
  logic [0:0]  out_exponent_h;
  logic [11:0] out_fraction_h;

  int   total = 0;
  int   bad   = 0;
  r32_t sb[$];
  r16_t sb16[$];
  logic acc, del, acc_h, del_h;

  posit_extract_pipe #(.NBITS(32), .ES(2), .TBITS(8)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_sign(out_sign),
    .out_scale(out_scale), .out_exponent(out_exponent), .out_fraction(out_fraction),
    .out_inf(out_inf), .out_zero(out_zero), .out_tag(out_tag)
  );

  posit_extract_pipe #(.NBITS(16), .ES(1), .TBITS(8)) dut16 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid_h), .in_ready(in_ready_h), .in_data(in_data_h), .in_tag(in_tag_h),
    .out_valid(out_valid_h), .out_ready(out_ready_h), .out_sign(out_sign_h),
    .out_scale(out_scale_h), .out_exponent(out_exponent_h), .out_fraction(out_fraction_h),
    .out_inf(out_inf_h), .out_zero(out_zero_h), .out_tag(out_tag_h)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference decoder: walks the word bit by bit with a position pointer.
  function automatic void model(input logic [63:0] win, input int nb, input int es,
                                output logic sg, output int sc, output int ex,
                                output longint fr, output logic inf, output logic zr);
    logic [63:0] mask, w, a;
    logic r0;
    int pos, m, k;
    mask = (64'd1 << nb) - 64'd1;
    w    = win & mask;
    sg   = w[nb-1];
    zr   = (w == 64'd0);
    inf  = (w == (64'd1 << (nb - 1)));
    a    = sg ? ((~w + 64'd1) & mask) : w;
    r0   = a[nb-2];
    pos  = nb - 2;
    m    = 0;
    while (pos >= 0 && a[pos] == r0) begin
      m++;
      pos--;
    end
    pos--;
    ex = 0;
    for (int j = 0; j < es; j++) begin
      ex = ex * 2 + ((pos >= 0) ? int'(a[pos]) : 0);
      pos--;
    end
    fr = 0;
    for (int j = 0; j < nb - 3 - es; j++) begin
      fr = fr * 2 + ((pos >= 0) ? longint'(a[pos]) : 0);
      pos--;
    end
    k  = r0 ? m - 1 : -m;
    sc = k * (1 << es) + ex;
    if (zr || inf) begin
      sg = 1'b0; sc = 0; ex = 0; fr = 0;
    end
  endfunction

  function automatic r32_t exp32(input logic [31:0] w, input logic [7:0] t);
    logic sg, inf, zr;
    int sc, ex;
    longint fr;
    model({32'd0, w}, 32, 2, sg, sc, ex, fr, inf, zr);
    return '{sg, 8'(sc), 2'(ex), 27'(fr), inf, zr, t};
  endfunction

  function automatic r16_t exp16(input logic [15:0] w, input logic [7:0] t);
    logic sg, inf, zr;
    int sc, ex;
    longint fr;
    model({48'd0, w}, 16, 1, sg, sc, ex, fr, inf, zr);
    return '{sg, 6'(sc), 1'(ex), 12'(fr), inf, zr, t};
  endfunction

  function automatic r32_t obs32();
    return {out_sign, out_scale, out_exponent, out_fraction, out_inf, out_zero, out_tag};
  endfunction

  function automatic r16_t obs16();
    return {out_sign_h, out_scale_h, out_exponent_h, out_fraction_h, out_inf_h, out_zero_h, out_tag_h};
  endfunction

  function automatic logic [31:0] rand_word();
    logic [31:0] sp [4] = '{32'h0000_0000, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001};
    if ($urandom_range(0, 7) == 0) return sp[$urandom_range(0, 3)];
    return $urandom;
  endfunction

  // Drive one cycle on the 32/2 instance; record transfers and push expectations.
  task automatic tick(input logic v, input logic [31:0] d, input logic [7:0] t, input logic rdy);
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    in_tag    = t;
    out_ready = rdy;
    #1;
    acc = in_valid && in_ready;
    del = out_valid && out_ready;
    if (acc) sb.push_back(exp32(d, t));
  endtask

  task automatic tick16(input logic v, input logic [15:0] d, input logic [7:0] t);
    @(negedge clk);
    in_valid_h  = v;
    in_data_h   = d;
    in_tag_h    = t;
    out_ready_h = 1'b1;
    #1;
    acc_h = in_valid_h && in_ready_h;
    del_h = out_valid_h && out_ready_h;
    if (acc_h) sb16.push_back(exp16(d, t));
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 1'b0; in_data = '0; in_tag = '0; out_ready = 1'b1;
    in_valid_h = 1'b0; in_data_h = '0; in_tag_h = '0; out_ready_h = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if (out_valid !== 1'b0 || obs32() !== '0)
      $display("FAIL reset_state: got valid=%b fields=%h want valid=0 fields=0", out_valid, obs32());
    total++;
    if (out_valid_h !== 1'b0 || obs16() !== '0)
      $display("FAIL reset_state16: got valid=%b fields=%h want 0", out_valid_h, obs16());
    reset = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready: got %b want 1", in_ready);
    end
    if (out_valid !== 1'b0 || obs32() !== '0) bad++;
    if (out_valid_h !== 1'b0 || obs16() !== '0) bad++;
  endtask

  task automatic test_decode_table();
    logic [31:0] words [8] = '{32'h4000_0000, 32'h4800_0000, 32'h4400_0000, 32'hC000_0000,
                               32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 32'h0000_0000};
    int          scl   [8] = '{0, 1, 0, 0, 120, -120, 0, 0};
    logic [26:0] frs   [8] = '{27'h0, 27'h0, 27'h400_0000, 27'h0, 27'h0, 27'h0, 27'h0, 27'h0};
    logic        infs  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic        zrs   [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    int first_out = -1;
    int nout = 0;
    r32_t e;
    for (int c = 0; c < 16; c++) begin
      if (c < 8) tick(1'b1, words[c], 8'(8'h20 + c), 1'b1);
      else       tick(1'b0, 32'h0, 8'h00, 1'b1);
      if (c < 8) begin
        total++;
        if (acc !== 1'b1) begin bad++; $display("FAIL decode_accept: got %b want 1", acc); end
      end
      if (del) begin
        if (first_out < 0) first_out = c;
        total++;
        if (sb.size() == 0 || nout >= 8) begin
          bad++; $display("FAIL decode_extra: got tag %h want no output", out_tag);
        end else begin
          e = sb.pop_front();
          if (obs32() !== e) begin
            bad++; $display("FAIL decode_fields: got %h want %h", obs32(), e);
          end
          total++;
          if (int'($signed(out_scale)) !== scl[nout] || out_fraction !== frs[nout] ||
              out_inf !== infs[nout] || out_zero !== zrs[nout] || out_tag !== 8'(8'h20 + nout)) begin
            bad++;
            $display("FAIL decode_table[%0d]: got scale=%0d frac=%h inf=%b zero=%b tag=%h want scale=%0d frac=%h inf=%b zero=%b",
                     nout, int'($signed(out_scale)), out_fraction, out_inf, out_zero, out_tag,
                     scl[nout], frs[nout], infs[nout], zrs[nout]);
          end
          nout++;
        end
      end
    end
    total++;
    if (first_out !== 2) begin bad++; $display("FAIL decode_latency: got %0d want 2", first_out); end
    total++;
    if (nout !== 8) begin bad++; $display("FAIL decode_count: got %0d want 8", nout); end
  endtask

  task automatic test_reset_midstream();
    tick(1'b1, 32'h4800_0000, 8'h01, 1'b1);
    tick(1'b1, 32'h7FFF_FFFF, 8'h02, 1'b1);
    @(posedge clk);
    #3;
    reset    = 1'b1;
    in_valid = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || obs32() !== '0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL midreset_clear: got valid=%b fields=%h ready=%b want 0/0/1", out_valid, obs32(), in_ready);
    end
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    for (int c = 0; c < 5; c++) begin
      tick(1'b0, 32'h0, 8'h00, 1'b1);
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL midreset_stale: got valid=%b tag=%h want 0", out_valid, out_tag); end
    end
  endtask

  task automatic test_back_to_back();
    int sent = 0, got = 0;
    logic prev_stall = 1'b0;
    logic v;
    r32_t prev_o, e;
    logic [31:0] wd;
    wd = rand_word();
    for (int c = 0; c < 3000 && got < 100; c++) begin
      v = (sent < 100) && ($urandom_range(0, 3) != 0);
      tick(v, wd, 8'(sent), 1'($urandom_range(0, 1)));
      total++;
      if (in_ready !== !(out_valid && !out_ready)) begin
        bad++; $display("FAIL b2b_ready: got %b want %b", in_ready, !(out_valid && !out_ready));
      end
      if (prev_stall) begin
        total++;
        if (out_valid !== 1'b1 || obs32() !== prev_o) begin
          bad++; $display("FAIL b2b_stable: got %h want %h", obs32(), prev_o);
        end
      end
      if (del) begin
        total++;
        if (sb.size() == 0) begin
          bad++; $display("FAIL b2b_extra: got tag %h want no output", out_tag);
        end else begin
          e = sb.pop_front();
          if (obs32() !== e) begin bad++; $display("FAIL b2b_data: got %h want %h", obs32(), e); end
        end
        got++;
      end
      prev_stall = out_valid && !out_ready;
      prev_o     = obs32();
      if (acc) begin
        sent++;
        wd = rand_word();
      end
    end
    total++;
    if (got !== 100 || sb.size() != 0) begin
      bad++; $display("FAIL b2b_count: got %0d outputs (%0d pending) want 100", got, sb.size());
    end
  endtask

  task automatic test_stall();
    logic [31:0] w [3];
    int idx = 0, got = 0;
    logic rdy;
    r32_t e;
    for (int i = 0; i < 3; i++) w[i] = $urandom;
    for (int c = 0; c < 20; c++) begin
      rdy = (c >= 2 && c < 6) ? 1'b0 : 1'b1;
      tick(idx < 3, (idx < 3) ? w[idx] : 32'h0, 8'(8'h40 + idx), rdy);
      if (c >= 2 && c < 6) begin
        total++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || sb.size() == 0 || obs32() !== sb[0]) begin
          bad++;
          $display("FAIL stall_hold: got ready=%b valid=%b fields=%h want ready=0 valid=1 first word (tag 40)",
                   in_ready, out_valid, obs32());
        end
      end
      if (del) begin
        total++;
        if (sb.size() == 0) begin
          bad++; $display("FAIL stall_extra: got tag %h want no output", out_tag);
        end else begin
          e = sb.pop_front();
          if (obs32() !== e) begin bad++; $display("FAIL stall_drain: got %h want %h", obs32(), e); end
        end
        got++;
      end
      if (acc) idx++;
    end
    total++;
    if (got !== 3 || sb.size() != 0) begin
      bad++; $display("FAIL stall_count: got %0d want 3", got);
    end
  endtask

  task automatic test_param16();
    logic [15:0] words [4] = '{16'h4000, 16'h7FFF, 16'h0001, 16'h5800};
    int          scl   [4] = '{0, 28, -28, 1};
    logic [11:0] frs   [4] = '{12'h000, 12'h000, 12'h000, 12'h800};
    int nout = 0;
    r16_t e;
    for (int c = 0; c < 10; c++) begin
      if (c < 4) tick16(1'b1, words[c], 8'(8'h60 + c));
      else       tick16(1'b0, 16'h0, 8'h00);
      if (del_h) begin
        total++;
        if (sb16.size() == 0 || nout >= 4) begin
          bad++; $display("FAIL p16_extra: got tag %h want no output", out_tag_h);
        end else begin
          e = sb16.pop_front();
          if (obs16() !== e) begin bad++; $display("FAIL p16_fields: got %h want %h", obs16(), e); end
          total++;
          if (int'($signed(out_scale_h)) !== scl[nout] || out_fraction_h !== frs[nout]) begin
            bad++;
            $display("FAIL p16_table[%0d]: got scale=%0d frac=%h want scale=%0d frac=%h",
                     nout, int'($signed(out_scale_h)), out_fraction_h, scl[nout], frs[nout]);
          end
          nout++;
        end
      end
    end
    total++;
    if (nout !== 4) begin bad++; $display("FAIL p16_count: got %0d want 4", nout); end
  endtask

  initial begin
    test_reset();
    test_decode_table();
    test_reset_midstream();
    test_back_to_back();
    test_stall();
    test_param16();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
